// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect controller for a 5-stage pipeline: load-use stall, branch/jump redirect,
// EX operand forwarding from shadow EX/MEM/WB destination slots, and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              kill_if,
  output logic              kill_id,
  output logic [1:0]        pc_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              ex_v_q,  ex_v_d,  ex_wr_q,  ex_wr_d,  ex_ld_q, ex_ld_d;
  logic              mem_v_q, mem_v_d, mem_wr_q, mem_wr_d, mem_ld_q, mem_ld_d;
  logic              wb_v_q,  wb_v_d,  wb_wr_q,  wb_wr_d,  wb_ld_q, wb_ld_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic       ld_use, stall_int, jump_go;
  logic [1:0] pc_src_int, fwd_a_int, fwd_b_int;

  function automatic logic slot_writes(input logic v, input logic wr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] r);
    return v && wr && (rd == r) && (r != '0);
  endfunction

  // A load still in EX yields 0: its data is not ready and the cycle is stalled anyway.
  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_ld,
                                         input logic mem_m, input logic wb_m);
    if (ex_m)       return ex_ld ? 2'd0 : 2'd1;
    else if (mem_m) return 2'd2;
    else if (wb_m)  return 2'd3;
    else            return 2'd0;
  endfunction

  always_comb begin
    ex_a  = id_rs1_used && slot_writes(ex_v_q,  ex_wr_q,  ex_rd_q,  id_rs1);
    ex_b  = id_rs2_used && slot_writes(ex_v_q,  ex_wr_q,  ex_rd_q,  id_rs2);
    mem_a = id_rs1_used && slot_writes(mem_v_q, mem_wr_q, mem_rd_q, id_rs1);
    mem_b = id_rs2_used && slot_writes(mem_v_q, mem_wr_q, mem_rd_q, id_rs2);
    wb_a  = id_rs1_used && slot_writes(wb_v_q,  wb_wr_q,  wb_rd_q,  id_rs1);
    wb_b  = id_rs2_used && slot_writes(wb_v_q,  wb_wr_q,  wb_rd_q,  id_rs2);

    ld_use    = id_valid && ex_ld_q && (ex_a || ex_b);
    stall_int = ld_use && !ex_branch_taken;
    jump_go   = !ex_branch_taken && !stall_int && id_jump && id_valid;

    if (ex_branch_taken) pc_src_int = 2'd2;
    else if (jump_go)    pc_src_int = 2'd1;
    else                 pc_src_int = 2'd0;

    fwd_a_int = fwd_sel(ex_a, ex_ld_q, mem_a, wb_a);
    fwd_b_int = fwd_sel(ex_b, ex_ld_q, mem_b, wb_b);

    // Outputs are forced quiet while reset is held, independent of the live ID/EX inputs.
    stall   = reset && stall_int;
    kill_if = reset && (ex_branch_taken || jump_go);
    kill_id = reset && ex_branch_taken;
    pc_src  = reset ? pc_src_int : 2'd0;
    fwd_a   = reset ? fwd_a_int  : 2'd0;
    fwd_b   = reset ? fwd_b_int  : 2'd0;
    stall_cycles = cnt_q;

    ex_v_d   = id_valid && !stall_int && !ex_branch_taken;
    ex_wr_d  = id_reg_wr;
    ex_ld_d  = id_mem_rd;
    ex_rd_d  = id_rd;
    mem_v_d  = ex_v_q;
    mem_wr_d = ex_wr_q;
    mem_ld_d = ex_ld_q;
    mem_rd_d = ex_rd_q;
    wb_v_d   = mem_v_q;
    wb_wr_d  = mem_wr_q;
    wb_ld_d  = mem_ld_q;
    wb_rd_d  = mem_rd_q;

    cnt_d = cnt_q;
    if (stall_int && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v_q   <= 1'b0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      ex_rd_q  <= '0;
      mem_v_q  <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_ld_q <= 1'b0;
      mem_rd_q <= '0;
      wb_v_q   <= 1'b0;
      wb_wr_q  <= 1'b0;
      wb_ld_q  <= 1'b0;
      wb_rd_q  <= '0;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      ex_rd_q  <= ex_rd_d;
      mem_v_q  <= mem_v_d;
      mem_wr_q <= mem_wr_d;
      mem_ld_q <= mem_ld_d;
      mem_rd_q <= mem_rd_d;
      wb_v_q   <= wb_v_d;
      wb_wr_q  <= wb_wr_d;
      wb_ld_q  <= wb_ld_d;
      wb_rd_q  <= wb_rd_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (CNT_W=4): directed scenarios plus a randomized run
// checked against an instruction-history model of the pipeline.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_mem_rd, id_jump, ex_branch_taken;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       stall, kill_if, kill_id;
  logic [1:0] pc_src, fwd_a, fwd_b;
  logic [3:0] stall_cycles;
  logic [8:0] dut_out;

  int total = 0;
  int bad = 0;

  typedef struct {bit v; bit wr; bit ld; bit [2:0] rd;} instr_t;
  instr_t hist[3];   // hist[0] = youngest instruction now in EX
  int     m_cnt;

  pipeline_hazard_ctrl #(.REG_AW(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .kill_if(kill_if), .kill_id(kill_id),
    .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  assign dut_out = {stall, kill_if, kill_id, pc_src, fwd_a, fwd_b};

  always #5 clk = ~clk;

  // Age of the youngest in-flight writer of r (-1 if none).
  function automatic int youngest_writer(input bit [2:0] r);
    for (int age = 0; age < 3; age++)
      if (r != 0 && hist[age].v && hist[age].wr && hist[age].rd == r) return age;
    return -1;
  endfunction

  function automatic bit [1:0] m_fwd(input bit [2:0] r, input bit used);
    int age;
    if (!used) return 2'd0;
    age = youngest_writer(r);
    if (age < 0) return 2'd0;
    if (age == 0) return hist[0].ld ? 2'd0 : 2'd1;
    return 2'(age + 1);
  endfunction

  function automatic bit m_needs_load(input bit [2:0] r, input bit used);
    return used && youngest_writer(r) == 0 && hist[0].ld;
  endfunction

  function automatic bit [8:0] model_out();
    bit s, kif, kid, jmp;
    bit [1:0] pcs;
    if (!reset) return 9'd0;
    s   = id_valid && (m_needs_load(id_rs1, id_rs1_used) || m_needs_load(id_rs2, id_rs2_used))
          && !ex_branch_taken;
    jmp = !ex_branch_taken && !s && id_jump && id_valid;
    kif = ex_branch_taken || jmp;
    kid = ex_branch_taken;
    pcs = ex_branch_taken ? 2'd2 : (jmp ? 2'd1 : 2'd0);
    return {s, kif, kid, pcs, m_fwd(id_rs1, id_rs1_used), m_fwd(id_rs2, id_rs2_used)};
  endfunction

  task automatic cycle();
    bit [8:0] e;
    e = model_out();
    if (!reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 3'd0};
      m_cnt = 0;
    end else begin
      if (e[8] && m_cnt < 15) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{id_valid && !e[8] && !e[6], id_reg_wr, id_mem_rd, id_rd};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [2:0] rs1, input bit u1, input bit [2:0] rs2,
                       input bit u2, input bit [2:0] rd, input bit wr, input bit ld,
                       input bit jmp, input bit br);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_mem_rd = ld; id_jump = jmp; ex_branch_taken = br;
    #1;
  endtask

  task automatic alu(input bit [2:0] rd, input bit [2:0] rs1, input bit [2:0] rs2);
    drive(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0);
  endtask

  task automatic lw(input bit [2:0] rd);
    drive(1, 3'd0, 1, 3'd0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic clean_pipe();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 1, 1, 1);
    total++;
    if (dut_out !== 9'd0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs got out=%b cnt=%0d want 0/0", dut_out, stall_cycles);
    end
    cycle();
    reset = 1'b1;
    clean_pipe();
    total++;
    if (dut_out !== 9'd0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL reset_release got out=%b cnt=%0d want 0/0", dut_out, stall_cycles);
    end
  endtask

  task automatic test_alu_chain();
    bit [1:0] exp_g[4];
    exp_g[0] = 2'd1; exp_g[1] = 2'd2; exp_g[2] = 2'd3; exp_g[3] = 2'd0;
    for (int gap = 0; gap < 4; gap++) begin
      clean_pipe();
      alu(1, 4, 5);
      cycle();
      repeat (gap) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
      end
      alu(2, 1, 3);
      total++;
      if (fwd_a !== exp_g[gap] || fwd_b !== 2'd0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL alu_gap%0d got fwd_a=%0d fwd_b=%0d stall=%b want %0d/0/0",
                 gap, fwd_a, fwd_b, stall, exp_g[gap]);
      end
      cycle();
    end
  endtask

  task automatic test_load_use();
    clean_pipe();
    lw(4);
    cycle();
    alu(5, 4, 4);
    total++;
    if (stall !== 1'b1 || kill_if !== 1'b0 || pc_src !== 2'd0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL load_use_stall got stall=%b kill_if=%b pc_src=%0d cnt=%0d want 1/0/0/0",
               stall, kill_if, pc_src, stall_cycles);
    end
    cycle();
    total++;
    if (stall !== 1'b0 || fwd_a !== 2'd2 || fwd_b !== 2'd2 || stall_cycles !== 4'd1) begin
      bad++;
      $display("FAIL load_use_after got stall=%b fwd_a=%0d fwd_b=%0d cnt=%0d want 0/2/2/1",
               stall, fwd_a, fwd_b, stall_cycles);
    end
    cycle();
    alu(6, 5, 4);
    total++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd3 || stall !== 1'b0) begin
      bad++;
      $display("FAIL load_use_bubble got fwd_a=%0d fwd_b=%0d stall=%b want 1/3/0",
               fwd_a, fwd_b, stall);
    end
    cycle();
  endtask

  task automatic test_r0_unused();
    clean_pipe();
    lw(0);
    cycle();
    alu(1, 0, 0);
    total++;
    if (stall !== 1'b0 || fwd_a !== 2'd0 || fwd_b !== 2'd0) begin
      bad++;
      $display("FAIL r0_load got stall=%b fwd_a=%0d fwd_b=%0d want 0/0/0", stall, fwd_a, fwd_b);
    end
    cycle();
    clean_pipe();
    lw(2);
    cycle();
    drive(1, 2, 0, 3, 1, 5, 1, 0, 0, 0);
    total++;
    if (stall !== 1'b0 || fwd_a !== 2'd0) begin
      bad++;
      $display("FAIL unused_src got stall=%b fwd_a=%0d want 0/0", stall, fwd_a);
    end
    cycle();
  endtask

  task automatic test_branch_collision();
    clean_pipe();
    lw(4);
    cycle();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 1);
    total++;
    if (stall !== 1'b0 || pc_src !== 2'd2 || kill_if !== 1'b1 || kill_id !== 1'b1) begin
      bad++;
      $display("FAIL branch_vs_stall got stall=%b pc_src=%0d kill_if=%b kill_id=%b want 0/2/1/1",
               stall, pc_src, kill_if, kill_id);
    end
    cycle();
    drive(1, 5, 1, 4, 1, 6, 1, 0, 0, 0);
    total++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd2 || stall !== 1'b0) begin
      bad++;
      $display("FAIL branch_bubble got fwd_a=%0d fwd_b=%0d stall=%b want 0/2/0",
               fwd_a, fwd_b, stall);
    end
    cycle();
  endtask

  task automatic test_jump_defer();
    clean_pipe();
    lw(4);
    cycle();
    drive(1, 4, 1, 0, 0, 7, 1, 0, 1, 0);
    total++;
    if (stall !== 1'b1 || pc_src !== 2'd0 || kill_if !== 1'b0 || kill_id !== 1'b0) begin
      bad++;
      $display("FAIL jump_deferred got stall=%b pc_src=%0d kill_if=%b kill_id=%b want 1/0/0/0",
               stall, pc_src, kill_if, kill_id);
    end
    cycle();
    total++;
    if (stall !== 1'b0 || pc_src !== 2'd1 || kill_if !== 1'b1 || kill_id !== 1'b0) begin
      bad++;
      $display("FAIL jump_taken got stall=%b pc_src=%0d kill_if=%b kill_id=%b want 0/1/1/0",
               stall, pc_src, kill_if, kill_id);
    end
    cycle();
  endtask

  task automatic test_saturation();
    clean_pipe();
    for (int i = 0; i < 18; i++) begin
      lw(4);
      cycle();
      alu(5, 4, 4);
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL sat_pair%0d got stall=%b want 1", i, stall);
      end
      cycle();
      cycle();
      if (i == 16) begin
        total++;
        if (stall_cycles !== 4'd15) begin
          bad++;
          $display("FAIL sat_reach got cnt=%0d want 15", stall_cycles);
        end
      end
    end
    total++;
    if (stall_cycles !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold got cnt=%0d want 15", stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    clean_pipe();
    alu(3, 0, 0);
    cycle();
    alu(2, 0, 0);
    cycle();
    lw(1);
    cycle();
    alu(5, 1, 2);
    total++;
    if (stall !== 1'b1 || fwd_b !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset got stall=%b fwd_b=%0d want 1/2", stall, fwd_b);
    end
    reset = 1'b0;
    #1;
    total++;
    if (dut_out !== 9'd0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL async_reset got out=%b cnt=%0d want 0/0", dut_out, stall_cycles);
    end
    drive(1, 1, 1, 2, 1, 5, 1, 0, 1, 1);
    total++;
    if (dut_out !== 9'd0) begin
      bad++;
      $display("FAIL reset_gates_redirect got out=%b want 0", dut_out);
    end
    cycle();
    reset = 1'b1;
    alu(5, 1, 1);
    total++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall !== 1'b0 || stall_cycles !== 4'd0) begin
      bad++;
      $display("FAIL post_reset got fwd_a=%0d fwd_b=%0d stall=%b cnt=%0d want 0/0/0/0",
               fwd_a, fwd_b, stall, stall_cycles);
    end
    cycle();
  endtask

  task automatic test_random();
    bit [8:0] e;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 3)), 1'($urandom),
            3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      e = model_out();
      total++;
      if (dut_out !== e || stall_cycles !== 4'(m_cnt)) begin
        bad++;
        $display("FAIL random_%0d got out=%b cnt=%0d want out=%b cnt=%0d",
                 i, dut_out, stall_cycles, e, m_cnt);
      end
      cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 3'd0};
    m_cnt = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_r0_unused();
    test_branch_collision();
    test_jump_defer();
    test_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and redirect controller for the 5-stage pipeline (IF, ID, EX, MEM, WB); it is the consumer end of the main control signals.
- Takes the decoded ID-stage controls (RegWr, MemRd, register numbers, jump) plus the EX branch outcome.
- Returns stall, kill and PcSrc to fetch and the control unit, and forwarding selects to the EX operand muxes.
- Keeps its own shadow copy of the destination-register info for the EX, MEM and WB stages.

Parameters:
REG_AW, 3, register-number width (8 registers; R0 hardwired zero)
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source 1 register
id_rs1_used  in  1  instruction reads rs1
id_rs2  in  REG_AW  source 2 register
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  destination register
id_reg_wr  in  1  RegWr control from decoder
id_mem_rd  in  1  MemRd control (load)
id_jump  in  1  unconditional jump resolved in ID
ex_branch_taken  in  1  conditional branch in EX resolved taken
stall  out  1  hold PC and IF/ID, insert bubble into EX
kill_if  out  1  squash instruction in IF
kill_id  out  1  squash instruction in ID
pc_src  out  2  0 = PC+1, 1 = jump target, 2 = branch target
fwd_a  out  2  operand A: 0 = regfile, 1 = EX/MEM ALU, 2 = MEM/WB, 3 = WB write data
fwd_b  out  2  same encoding for operand B
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
Shadow slots:
- Three slots: EX, MEM and WB. Each holds {v, wr, ld, rd}.
- A slot "writes r" when v=1, wr=1, rd==r and r!=0.

Slot update on each rising clk:
- WB gets MEM.
- MEM gets EX.
- EX gets the ID inputs (v=id_valid), unless stall, kill_id or !id_valid is true. In that case EX gets a bubble (v=0).

Outputs (all combinational from slots and current inputs):
- Load-use hazard: the EX slot has ld=1 and writes a register that ID actually reads (id_rs1 with id_rs1_used, or id_rs2 with id_rs2_used), and id_valid=1.
- stall = load-use hazard AND NOT ex_branch_taken.
- Forwarding per operand, priority EX > MEM > WB:
  - EX slot writes rs and ld=0: select 1.
  - else MEM slot writes rs: select 2 (this covers the load result one cycle after the stall).
  - else WB slot writes rs: select 3.
  - else select 0.
  - An EX-slot load match selects 0 (the cycle is stalled anyway).
  - Operands that are not used select 0.

Redirect priority:
- ex_branch_taken: pc_src=2, kill_if=1, kill_id=1, stall=0. Gives two bubbles.
- else stall: pc_src=0, kill_if=0, kill_id=0. A jump in ID is deferred until the stall clears.
- else id_jump && id_valid: pc_src=1, kill_if=1, kill_id=0. Gives one bubble.
- else: pc_src=0, kills=0.

Rules:
- Latency: a stall lasts exactly 1 cycle per load-use pair.
- Back-to-back loads are handled independently.
- Register 0 never causes a hazard or a forward.

stall_cycles:
- Increments on each clk with stall=1.
- Saturates at all-ones and never wraps.

Reset (reset=0, asserted at any time):
- All slots v=0. stall_cycles=0.
- Hence stall=0, kills=0, pc_src=0 and fwd=0 immediately, combinationally, mid-operation included.
- Deassertion is taken synchronously at the next edge. The first instruction after reset sees empty slots.

Test Plan:
- ALU chain: ADD R1 then ADD R2,R1,R3 on the next cycle -> fwd_a=1 at the second instruction's ID-to-EX cycle. One instruction gap -> fwd_a=2. Two gaps -> fwd_a=3. Three gaps -> 0. stall stays 0 throughout.
- Load-use: LW R4 followed by ADD R5,R4,R4 -> stall=1 for exactly 1 cycle and an EX bubble. Next cycle fwd_a=fwd_b=2, stall=0. stall_cycles goes from 0 to 1.
- R0 and unused sources: LW R0 followed by ADD R1,R0,R0 -> no stall, fwd=0. Load to R2 followed by an instruction with id_rs1=2 but id_rs1_used=0 -> no stall.
- Redirect collisions:
  - Load-use stall with ex_branch_taken=1 in the same cycle -> stall=0, pc_src=2, kill_if=kill_id=1, and EX receives a bubble.
  - Stall concurrent with id_jump -> pc_src=0 that cycle, then pc_src=1 with kill_if=1 on the next cycle.
- Counter saturation with CNT_W=4: drive 17 load-use pairs -> stall_cycles=15 and it stays at 15.
- Async reset mid-stream: assert reset between edges while stall=1 and slots are full -> outputs go to 0 immediately. After release, an instruction reading R1 gets fwd=0 even though R1 was in flight before reset.
